// File: rtl/sqrt_share_arbiter_pkg.sv
// sqrt_share_arbiter_pkg: tag width helper and round-robin winner search shared by the arbiter.
package sqrt_share_arbiter_pkg;
    localparam int MAX_REQ   = 8;
    localparam int MAX_TAG_W = 3;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First valid index at or after ptr, wrapping modulo n; returns ptr when nothing is valid.
    function automatic logic [MAX_TAG_W-1:0] rr_find(input logic [MAX_REQ-1:0] valid,
                                                     input logic [MAX_TAG_W-1:0] ptr,
                                                     input int n);
        logic [MAX_TAG_W-1:0] w;
        int idx;
        w = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (valid[idx[MAX_TAG_W-1:0]]) w = idx[MAX_TAG_W-1:0];
        end
        return w;
    endfunction
endpackage

// File: rtl/sqrt_tag_fifo.sv
// sqrt_tag_fifo: in-order FIFO of requester tags for results still inside the sqrt unit.
module sqrt_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full_o  = cnt_q == (AW+1)'(DEPTH);
        empty_o = cnt_q == '0;
        count_o = cnt_q;
        dout_o  = mem_q[rd_q];
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: round-robin sharing of one in-order sqrt unit, results steered back by tag.
module sqrt_share_arbiter
    import sqrt_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_WIDTH     = 32,
    parameter int OUTPUT_WIDTH    = (INPUT_WIDTH + 1) / 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [OUTPUT_WIDTH-1:0]            rsp_data,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [INPUT_WIDTH-1:0]             sqrt_in_data,
    output logic                               sqrt_in_valid,
    input  logic                               sqrt_in_ready,
    input  logic [OUTPUT_WIDTH-1:0]            sqrt_out_data,
    input  logic                               sqrt_out_valid,
    output logic                               sqrt_out_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_orphan
);
    localparam int TAG_W = tag_width(NUM_REQ);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, winner, head;
    logic             full, empty, push, pop, err_orphan_q, err_orphan_d;

    assign winner = TAG_W'(rr_find(MAX_REQ'(req_valid), MAX_TAG_W'(rr_ptr_q), NUM_REQ));

    always_comb begin
        sqrt_in_valid  = ~full & (|req_valid);
        sqrt_in_data   = req_data[winner*INPUT_WIDTH +: INPUT_WIDTH];
        push           = sqrt_in_valid & sqrt_in_ready;
        req_ready      = push ? NUM_REQ'(1) << winner : '0;
        rr_ptr_d       = push ? ((winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1) : rr_ptr_q;
        // With no tag pending the result is drained and flagged rather than delivered.
        rsp_valid      = empty ? '0 : NUM_REQ'(sqrt_out_valid) << head;
        rsp_data       = sqrt_out_data;
        sqrt_out_ready = empty | rsp_ready[head];
        pop            = ~empty & sqrt_out_valid & rsp_ready[head];
        err_orphan_d   = err_orphan_q | (empty & sqrt_out_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

    sqrt_tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (winner),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );
endmodule

// File: doc/sqrt_share_arbiter.md
# sqrt_share_arbiter

Shares one fixed-point square-root unit between NUM_REQ independent requesters. Incoming operands are granted round-robin onto the unit's valid/ready input. Results are steered back to the originating requester via an in-order tag FIFO. The block sits between client datapaths and a single `fixed_point_sqrt` instance; it adds no cycles on the issue or return path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- INPUT_WIDTH, 32, operand width
- OUTPUT_WIDTH, (INPUT_WIDTH+1)/2, result width
- MAX_OUTSTANDING, 4, tag FIFO depth; power of two, ≥ 2
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_data  in  NUM_REQ*INPUT_WIDTH  operand of requester i at bits [i*INPUT_WIDTH +: INPUT_WIDTH]
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept
- rsp_data  out  OUTPUT_WIDTH  result, broadcast to all requesters
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_ready  in  NUM_REQ  per-requester result accept
- sqrt_in_data  out  INPUT_WIDTH  operand to the sqrt unit
- sqrt_in_valid  out  1  operand valid to the sqrt unit
- sqrt_in_ready  in  1  sqrt unit accepts
- sqrt_out_data  in  OUTPUT_WIDTH  result from the sqrt unit
- sqrt_out_valid  in  1  result valid from the sqrt unit
- sqrt_out_ready  out  1  arbiter accepts the result
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  operations issued but not yet returned
- err_orphan  out  1  sticky; set when a result arrives with no tag pending

## Operation
- Handshake rule: standard valid/ready. A transfer occurs when valid & ready are high on a rising edge.
  - Requesters hold data stable while valid.
  - valid must not depend on ready.
- Grant: round-robin pointer `rr_ptr` (reset 0).
  - The winner is the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - The grant is combinational from req_valid and rr_ptr.
- Issue path:
  - `can_issue` = ~fifo_full & any req_valid.
  - sqrt_in_valid = can_issue.
  - sqrt_in_data = req_data of the winner.
  - req_ready[i] = winner[i] & sqrt_in_ready & ~fifo_full.
  - All other req_ready bits are 0.
- On an issue handshake:
  - push the winner index into the tag FIFO;
  - set rr_ptr to (winner+1) mod NUM_REQ.
  - With no handshake, rr_ptr holds its value.
- Full rule: fifo_full blocks issue even if a pop occurs in the same cycle. There is no bypass.
- Return path when the FIFO is non-empty, with head tag h:
  - rsp_valid[h] = sqrt_out_valid;
  - rsp_data = sqrt_out_data;
  - sqrt_out_ready = rsp_ready[h].
  - Pop on the handshake.
- Return path when the FIFO is empty:
  - rsp_valid = 0;
  - sqrt_out_ready = 1, so a stray result is drained;
  - if sqrt_out_valid is high, set err_orphan. It clears only on rst.
- Simultaneous push and pop in one cycle:
  - both take effect;
  - outstanding is unchanged.
- Ordering: results return in issue order. The sqrt unit is required to be in-order.
- Reset mid-operation:
  - the FIFO is emptied;
  - rr_ptr = 0;
  - outstanding = 0.
  - The sqrt unit must be reset on the same cycle. Any result arriving afterwards is an orphan.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, sqrt_in_valid = 0;
  - sqrt_out_ready = 1 (FIFO empty);
  - outstanding = 0, err_orphan = 0;
  - sqrt_in_data and rsp_data are don't-care.
- Issue latency is 0 cycles: the request handshake and the sqrt-input handshake occur on the same edge.
- Return latency is 0 cycles: the sqrt-output handshake and the response handshake occur on the same edge.
- End-to-end latency equals the sqrt unit latency.
- Throughput is one issue per cycle, limited by sqrt_in_ready and MAX_OUTSTANDING.
- outstanding updates on the edge after the handshake.

## Structure
- Shared package holds:
  - the tag width constant TAG_W = $clog2(NUM_REQ), minimum 1;
  - the round-robin find-first function.
- One sub-module: `sqrt_tag_fifo`.
  - Synchronous FIFO, width TAG_W, depth MAX_OUTSTANDING.
  - Ports: full, empty, count; push and pop allowed on the same cycle.
- Arbiter logic and return steering live in the top module.

## Test plan
- Single requester: requester 2 sends 0x00040000 (Q16.16 4.0); sqrt model has 3-cycle latency.
  - Required: rsp_valid = 4'b0100 with rsp_data = 0x0200 exactly 3 cycles later.
  - Required: outstanding goes 0→1→0.
- Fairness: all 4 requesters hold valid with sqrt_in_ready = 1.
  - Required: grant order 0,1,2,3,0,… with one issue per cycle.
  - Required: each result is returned to its issuer.
- Full FIFO: MAX_OUTSTANDING=4; sqrt_out_ready path stalled (rsp_ready=0); 6 requests offered.
  - Required: exactly 4 accepted, then req_ready = 0.
  - Required: after one rsp_ready, exactly one more is accepted on the following cycle, not the same cycle.
- Backpressure: sqrt_in_ready = 0 for 5 cycles with requester 1 valid.
  - Required: req_ready[1] = 0, rr_ptr unchanged, no push.
  - Required: issue on the first cycle sqrt_in_ready = 1.
- Orphan result: sqrt_out_valid pulsed with the FIFO empty.
  - Required: sqrt_out_ready = 1, no rsp_valid, err_orphan = 1 until rst.
- Reset mid-flight: 3 outstanding ops, then rst for 1 cycle.
  - Required: outstanding = 0, all rsp_valid = 0, rr_ptr = 0.
  - Required: the next request from requester 3 is granted first.
